vend_fsm_multi: RTL and testbench

Parametrised successor to the single-product vending FSM. It accepts three coin denominations and serves NUM_ITEMS product slots, each with its own stock counter. Change and cancelled credit are refunded serially, one unit per cycle. It sits between the coin-acceptor/keypad front end and the dispenser/change-hopper drivers.

---
 rtl/vend_pkg.sv | 15 +
 rtl/vend_fsm_multi_if.sv | 31 +++
 rtl/vend_stock_bank.sv | 40 ++++
 rtl/vend_fsm_multi.sv | 152 +++++++++++++++
 tb/tb_vend_fsm_multi.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// vend_pkg: shared state encoding and coin codes for the multi-slot vending controller.
package vend_pkg;

  typedef logic [1:0] state_t;

  localparam state_t COLLECT = 2'd0;
  localparam state_t VEND    = 2'd1;
  localparam state_t REFUND  = 2'd2;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_C1   = 2'b01;
  localparam logic [1:0] COIN_C2   = 2'b10;
  localparam logic [1:0] COIN_C3   = 2'b11;

endpackage

// File: rtl/vend_fsm_multi_if.sv
// vend_fsm_multi_if: front-end requests in, dispenser/hopper pulses and status out.
interface vend_fsm_multi_if #(
  parameter int NUM_ITEMS = 4,
  parameter int CRED_W    = 5,
  parameter int SEL_W     = $clog2(NUM_ITEMS)
);

  logic [1:0]           coin;
  logic [SEL_W-1:0]     sel;
  logic                 sel_vld;
  logic                 cancel;
  logic                 vend;
  logic [SEL_W-1:0]     vend_item;
  logic                 chg;
  logic                 coin_rej;
  logic                 sel_err;
  logic                 busy;
  logic [CRED_W-1:0]    credit;
  logic [NUM_ITEMS-1:0] sold_out;

  modport master (
    output coin, sel, sel_vld, cancel,
    input  vend, vend_item, chg, coin_rej, sel_err, busy, credit, sold_out
  );

  modport slave (
    input  coin, sel, sel_vld, cancel,
    output vend, vend_item, chg, coin_rej, sel_err, busy, credit, sold_out
  );

endinterface

// File: rtl/vend_stock_bank.sv
// vend_stock_bank: one stock counter per slot, decremented by strobe, with a registered sold-out map.
module vend_stock_bank #(
  parameter int NUM_ITEMS  = 4,
  parameter int STOCK_INIT = 7,
  parameter int STOCK_W    = 4,
  parameter int SEL_W      = $clog2(NUM_ITEMS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dec,
  input  logic [SEL_W-1:0]     idx,
  output logic [NUM_ITEMS-1:0] empty,
  output logic [NUM_ITEMS-1:0] sold_out
);

  logic [STOCK_W-1:0] stock [NUM_ITEMS];

  // Reload every slot on reset; take one unit from the indexed slot, never below zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_ITEMS; k++) stock[k] <= STOCK_W'(STOCK_INIT);
    end else if (dec) begin
      for (int k = 0; k < NUM_ITEMS; k++) begin
        if (idx == SEL_W'(k) && stock[k] != '0) stock[k] <= stock[k] - STOCK_W'(1);
      end
    end
  end

  // Live zero flags, used for the purchase check so it never lags the counters.
  always_comb begin
    for (int k = 0; k < NUM_ITEMS; k++) empty[k] = (stock[k] == '0);
  end

  // Registered copy for the outside world, one cycle behind the counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sold_out <= '0;
    else     sold_out <= empty;
  end

endmodule

// File: rtl/vend_fsm_multi.sv
// vend_fsm_multi: three-coin, multi-slot vending FSM with serial change/refund.
module vend_fsm_multi
  import vend_pkg::*;
#(
  parameter int COIN1_VAL  = 1,
  parameter int COIN2_VAL  = 2,
  parameter int COIN3_VAL  = 5,
  parameter int PRICE      = 3,
  parameter int NUM_ITEMS  = 4,
  parameter int STOCK_INIT = 7,
  parameter int CRED_W     = 5,
  parameter int STOCK_W    = 4,
  parameter int SEL_W      = $clog2(NUM_ITEMS)
) (
  input  logic            clk,
  input  logic            rst,
  vend_fsm_multi_if.slave bus
);

  localparam logic [CRED_W:0]   CRED_MAX = (CRED_W+1)'((1 << CRED_W) - 1);
  localparam logic [CRED_W-1:0] PRICE_C  = CRED_W'(PRICE);

  state_t               state, state_n;
  logic [CRED_W-1:0]    credit, credit_n;
  logic [SEL_W-1:0]     item, item_n;
  logic                 vend_pulse, vend_n;
  logic                 chg_pulse, chg_n;
  logic                 rej_pulse, rej_n;
  logic                 err_pulse, err_n;
  logic                 dec;
  logic                 coin_in;
  logic                 sel_ok;
  logic [CRED_W:0]      coin_val;
  logic [CRED_W:0]      sum;
  logic [NUM_ITEMS-1:0] empty;
  logic [NUM_ITEMS-1:0] sold_out;

  vend_stock_bank #(
    .NUM_ITEMS (NUM_ITEMS),
    .STOCK_INIT(STOCK_INIT),
    .STOCK_W   (STOCK_W),
    .SEL_W     (SEL_W)
  ) u_stock (
    .clk     (clk),
    .rst     (rst),
    .dec     (dec),
    .idx     (bus.sel),
    .empty   (empty),
    .sold_out(sold_out)
  );

  assign coin_in = (bus.coin != COIN_NONE);
  assign sum     = {1'b0, credit} + coin_val;

  // Translate the coin code into credit units.
  always_comb begin
    case (bus.coin)
      COIN_C1: coin_val = (CRED_W+1)'(COIN1_VAL);
      COIN_C2: coin_val = (CRED_W+1)'(COIN2_VAL);
      COIN_C3: coin_val = (CRED_W+1)'(COIN3_VAL);
      default: coin_val = '0;
    endcase
  end

  // A request is serviceable only if it names an existing slot that still has stock.
  always_comb begin
    sel_ok = 1'b0;
    for (int k = 0; k < NUM_ITEMS; k++) begin
      if (bus.sel == SEL_W'(k) && !empty[k]) sel_ok = 1'b1;
    end
  end

  // Next-state logic: vend work and each change pulse happen on the edge that enters the cycle showing them.
  always_comb begin
    state_n  = state;
    credit_n = credit;
    item_n   = item;
    vend_n   = 1'b0;
    chg_n    = 1'b0;
    rej_n    = 1'b0;
    err_n    = 1'b0;
    dec      = 1'b0;
    case (state)
      COLLECT: begin
        if (bus.cancel) begin
          rej_n = coin_in;
          if (credit != '0) begin
            state_n  = REFUND;
            chg_n    = 1'b1;
            credit_n = credit - CRED_W'(1);
          end
        end else if (bus.sel_vld) begin
          rej_n = coin_in;
          if (sel_ok && credit >= PRICE_C) begin
            state_n  = VEND;
            vend_n   = 1'b1;
            item_n   = bus.sel;
            dec      = 1'b1;
            credit_n = credit - PRICE_C;
          end else begin
            err_n = 1'b1;
          end
        end else if (coin_in) begin
          if (sum <= CRED_MAX) credit_n = sum[CRED_W-1:0];
          else                 rej_n    = 1'b1;
        end
      end
      VEND, REFUND: begin
        rej_n = coin_in;
        if (credit != '0) begin
          state_n  = REFUND;
          chg_n    = 1'b1;
          credit_n = credit - CRED_W'(1);
        end else begin
          state_n = COLLECT;
        end
      end
      default: state_n = COLLECT;
    endcase
  end

  // State, credit and all output pulses are registered; reset drops any pulse in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= COLLECT;
      credit     <= '0;
      item       <= '0;
      vend_pulse <= 1'b0;
      chg_pulse  <= 1'b0;
      rej_pulse  <= 1'b0;
      err_pulse  <= 1'b0;
    end else begin
      state      <= state_n;
      credit     <= credit_n;
      item       <= item_n;
      vend_pulse <= vend_n;
      chg_pulse  <= chg_n;
      rej_pulse  <= rej_n;
      err_pulse  <= err_n;
    end
  end

  assign bus.vend      = vend_pulse;
  assign bus.vend_item = item;
  assign bus.chg       = chg_pulse;
  assign bus.coin_rej  = rej_pulse;
  assign bus.sel_err   = err_pulse;
  assign bus.busy      = (state != COLLECT);
  assign bus.credit    = credit;
  assign bus.sold_out  = sold_out;

endmodule

// File: tb/tb_vend_fsm_multi.sv
// tb_vend_fsm_multi: directed scenarios plus random traffic against a schedule-based reference model.
module tb_vend_fsm_multi;

  localparam int NI         = 3;
  localparam int PRICE      = 3;
  localparam int CRED_MAX   = 31;
  localparam int STOCK_INIT = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int num_checks = 0;
  int num_errors = 0;

  vend_fsm_multi_if #(.NUM_ITEMS(NI), .CRED_W(5)) bus ();

  vend_fsm_multi #(
    .COIN1_VAL (1),
    .COIN2_VAL (2),
    .COIN3_VAL (5),
    .PRICE     (PRICE),
    .NUM_ITEMS (NI),
    .STOCK_INIT(STOCK_INIT),
    .CRED_W    (5),
    .STOCK_W   (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // One upcoming busy cycle as seen from the outside: vend pulse or change pulse, and credit shown.
  typedef struct {
    bit v;
    int item;
    bit c;
    int cr;
  } entry_t;

  entry_t         sched[$];
  int             mcredit;
  int             stock[NI];
  bit             e_vend, e_chg, e_rej, e_err, e_busy;
  int             e_item;
  logic [NI-1:0]  e_sold;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mcredit = 0;
    for (int k = 0; k < NI; k++) stock[k] = STOCK_INIT;
    sched.delete();
    e_vend = 0; e_chg = 0; e_rej = 0; e_err = 0; e_busy = 0;
    e_item = 0;
    e_sold = '0;
  endtask

  task automatic pushRefund(input int units);
    entry_t en;
    for (int i = units - 1; i >= 0; i--) begin
      en = '{1'b0, 0, 1'b1, i};
      sched.push_back(en);
    end
  endtask

  // Advance the model by one clock edge given the inputs held during the cycle just ending.
  task automatic modelStep(input logic [1:0] c, input int s, input bit v, input bit x);
    entry_t en;
    int val;
    e_vend = 0; e_chg = 0; e_rej = 0; e_err = 0;
    for (int k = 0; k < NI; k++) e_sold[k] = (stock[k] == 0);
    if (sched.size() != 0) begin
      e_rej = (c != 2'b00);
      void'(sched.pop_front());
    end else if (x) begin
      e_rej = (c != 2'b00);
      pushRefund(mcredit);
    end else if (v) begin
      e_rej = (c != 2'b00);
      if (s < NI && stock[s] > 0 && mcredit >= PRICE) begin
        stock[s] = stock[s] - 1;
        en = '{1'b1, s, 1'b0, mcredit - PRICE};
        sched.push_back(en);
        pushRefund(mcredit - PRICE);
      end else begin
        e_err = 1;
      end
    end else if (c != 2'b00) begin
      val = (c == 2'b01) ? 1 : (c == 2'b10) ? 2 : 5;
      if (mcredit + val <= CRED_MAX) mcredit = mcredit + val;
      else                           e_rej = 1;
    end
    if (sched.size() != 0) begin
      e_vend  = sched[0].v;
      e_chg   = sched[0].c;
      mcredit = sched[0].cr;
      if (sched[0].v) e_item = sched[0].item;
    end
    e_busy = (sched.size() != 0);
  endtask

  task automatic compareAll();
    checkOutput("vend", bus.vend, e_vend);
    checkOutput("chg", bus.chg, e_chg);
    checkOutput("coin_rej", bus.coin_rej, e_rej);
    checkOutput("sel_err", bus.sel_err, e_err);
    checkOutput("busy", bus.busy, e_busy);
    checkOutput("credit", bus.credit, mcredit);
    checkOutput("sold_out", bus.sold_out, e_sold);
    if (e_vend) checkOutput("vend_item", bus.vend_item, e_item);
  endtask

  // Drive one cycle of inputs (called away from the edge), step the model at the edge, check just after.
  task automatic applyStimulus(input logic [1:0] c, input int s, input bit v, input bit x);
    bus.coin    = c;
    bus.sel     = 2'(s);
    bus.sel_vld = v;
    bus.cancel  = x;
    @(posedge clk);
    modelStep(c, s, v, x);
    #1;
    compareAll();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(2'b00, 0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [1:0] rc;
    int rs;
    bit rv, rx;

    bus.coin = 2'b00; bus.sel = '0; bus.sel_vld = 1'b0; bus.cancel = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    compareAll();
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] coin 5, buy slot 2, two change pulses");
    applyStimulus(2'b11, 0, 1'b0, 1'b0);
    applyStimulus(2'b00, 2, 1'b1, 1'b0);
    idle(4);

    $display("[TB] exact price buy of slot 0");
    applyStimulus(2'b01, 0, 1'b0, 1'b0);
    applyStimulus(2'b10, 0, 1'b0, 1'b0);
    applyStimulus(2'b00, 0, 1'b1, 1'b0);
    idle(2);

    $display("[TB] cancel with credit 3, coin during refund");
    applyStimulus(2'b10, 0, 1'b0, 1'b0);
    applyStimulus(2'b01, 0, 1'b0, 1'b0);
    applyStimulus(2'b00, 0, 1'b0, 1'b1);
    applyStimulus(2'b11, 0, 1'b0, 1'b0);
    idle(4);

    $display("[TB] low credit, overflow coin, out-of-range slot");
    applyStimulus(2'b10, 0, 1'b0, 1'b0);
    applyStimulus(2'b00, 0, 1'b1, 1'b0);
    applyStimulus(2'b00, 0, 1'b0, 1'b1);
    idle(3);
    repeat (6) applyStimulus(2'b11, 0, 1'b0, 1'b0);
    applyStimulus(2'b10, 0, 1'b0, 1'b0);
    applyStimulus(2'b00, 3, 1'b1, 1'b0);
    applyStimulus(2'b00, 0, 1'b0, 1'b1);
    idle(32);

    $display("[TB] reset during refund");
    applyStimulus(2'b11, 0, 1'b0, 1'b0);
    applyStimulus(2'b00, 0, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    compareAll();
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] drain slot 1");
    for (int n = 0; n < 8; n++) begin
      applyStimulus(2'b01, 0, 1'b0, 1'b0);
      applyStimulus(2'b10, 0, 1'b0, 1'b0);
      applyStimulus(2'b00, 1, 1'b1, 1'b0);
      applyStimulus(2'b00, 0, 1'b0, 1'b0);
    end
    applyStimulus(2'b00, 0, 1'b0, 1'b1);
    idle(4);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      rc = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      rs = int'($urandom_range(0, 3));
      rv = ($urandom_range(0, 7) == 0);
      rx = ($urandom_range(0, 24) == 0);
      applyStimulus(rc, rs, rv, rx);
    end

    $display("CHECKS %0d ERRORS %0d", num_checks, num_errors);
    $finish;
  end

endmodule
